// File: rtl/wb_melody_player.sv
// wb_melody_player
// Wishbone bus master that walks a melody table in memory and plays each
// entry on the note-generator peripheral. Each table entry is two words:
// the frequency word, then the duration word in ticks. A non-zero
// frequency is written to the peripheral's freq register, followed by a
// go write (0) to its stop register. The note is held for the programmed
// number of ticks and then silenced with a stop write (1). A zero
// frequency is a rest: no freq or go write is made, but the stop write
// still follows the wait.
//
// Ports
//   clk, reset          clock and asynchronous active-high reset
//   start               one-cycle pulse, begins playback when idle
//   abort               one-cycle pulse, ends playback early
//   table_addr          byte address of the first entry (sampled on start)
//   note_count          number of entries (sampled on start)
//   busy                high from an accepted start until back in idle
//   done                one-cycle pulse when playback ends
//   m_cyc_o .. m_ack_i  Wishbone classic single-cycle master port
//
// Optional build macro: WB_MELODY_LOOP_EN. When it is defined, the table
// repeats from table_addr forever and playback ends only through abort.

module wb_melody_player #(
  parameter logic [31:0] NOTAS_BASE = 32'h0000_0000,
  parameter int          TICK_DIV   = 50000,
  parameter int          DUR_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] table_addr,
  input  logic [15:0] note_count,
  output logic        busy,
  output logic        done,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [31:0] m_adr_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_FREQ,
    S_RD_DUR,
    S_WR_FREQ,
    S_WR_GO,
    S_WAIT,
    S_WR_STOP,
    S_FIN
  } state_t;

  localparam logic [31:0]      PRESC_LAST = 32'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [31:0]      FREQ_ADDR  = NOTAS_BASE;
  localparam logic [31:0]      STOP_ADDR  = NOTAS_BASE + 32'h4;

  state_t           state;
  state_t           state_next;
  logic             phase;
  logic [31:0]      ptr;
  logic [15:0]      remaining;
  logic [31:0]      freq_r;
  logic [DUR_W-1:0] dur_r;
  logic             abort_pend;
  logic [31:0]      presc;
  logic [DUR_W-1:0] ticks;
`ifdef WB_MELODY_LOOP_EN
  logic [31:0]      first_addr;
  logic [15:0]      first_count;
`endif

  logic bus_state;
  logic req;
  logic abort_eff;
  logic wait_expired;

  // Every bus state runs one transfer in two phases: phase 0 holds the
  // request until ack, phase 1 is the mandatory idle cycle after it. The
  // state advances only out of phase 1.
  assign bus_state = (state == S_RD_FREQ) || (state == S_RD_DUR) ||
                     (state == S_WR_FREQ) || (state == S_WR_GO)  ||
                     (state == S_WR_STOP);
  assign req       = bus_state && !phase;

  // An abort arriving in the very cycle a decision is made still counts.
  assign abort_eff = abort_pend || abort;

  // Wait is dur_r * TICK_DIV cycles long; a zero duration still spends one
  // cycle in the state.
  assign wait_expired = (dur_r == '0) ||
                        ((presc == PRESC_LAST) && (ticks == dur_r - DUR_ONE));

  assign m_sel_o = 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (note_count == 16'd0) ? S_FIN : S_RD_FREQ;
        end
      end
      S_RD_FREQ: begin
        if (phase) begin
          state_next = abort_eff ? S_WR_STOP : S_RD_DUR;
        end
      end
      S_RD_DUR: begin
        if (phase) begin
          if (abort_eff) begin
            state_next = S_WR_STOP;
          end else if (freq_r == 32'd0) begin
            state_next = S_WAIT;
          end else begin
            state_next = S_WR_FREQ;
          end
        end
      end
      S_WR_FREQ: begin
        if (phase) begin
          state_next = abort_eff ? S_WR_STOP : S_WR_GO;
        end
      end
      S_WR_GO: begin
        if (phase) begin
          state_next = abort_eff ? S_WR_STOP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_eff || wait_expired) begin
          state_next = S_WR_STOP;
        end
      end
      S_WR_STOP: begin
        if (phase) begin
          if (abort_eff) begin
            state_next = S_FIN;
          end else if (remaining == 16'd1) begin
`ifdef WB_MELODY_LOOP_EN
            state_next = S_RD_FREQ;
`else
            state_next = S_FIN;
`endif
          end else begin
            state_next = S_RD_FREQ;
          end
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Bus outputs decode registered state only, so an asynchronous reset
  // drops cyc/stb at once and nothing combinationally follows m_ack_i.
  always_comb begin
    busy    = (state != S_IDLE);
    done    = (state == S_FIN);
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_adr_o = 32'd0;
    m_dat_o = 32'd0;
    if (req) begin
      m_cyc_o = 1'b1;
      m_stb_o = 1'b1;
      unique case (state)
        S_RD_FREQ: begin
          m_adr_o = ptr;
        end
        S_RD_DUR: begin
          m_adr_o = ptr + 32'd4;
        end
        S_WR_FREQ: begin
          m_we_o  = 1'b1;
          m_adr_o = FREQ_ADDR;
          m_dat_o = freq_r;
        end
        S_WR_GO: begin
          m_we_o  = 1'b1;
          m_adr_o = STOP_ADDR;
          m_dat_o = 32'd0;
        end
        S_WR_STOP: begin
          m_we_o  = 1'b1;
          m_adr_o = STOP_ADDR;
          m_dat_o = 32'd1;
        end
        default: begin
          m_adr_o = 32'd0;
        end
      endcase
    end
  end

  // Datapath: transfer phase, captured table words, table pointer, the
  // pending abort flag and the tick prescaler used while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= 1'b0;
      ptr        <= 32'd0;
      remaining  <= 16'd0;
      freq_r     <= 32'd0;
      dur_r      <= '0;
      abort_pend <= 1'b0;
      presc      <= 32'd0;
      ticks      <= '0;
`ifdef WB_MELODY_LOOP_EN
      first_addr  <= 32'd0;
      first_count <= 16'd0;
`endif
    end else begin
      if (state_next != state) begin
        phase <= 1'b0;
      end else if (req && m_ack_i) begin
        phase <= 1'b1;
      end

      if (req && m_ack_i && (state == S_RD_FREQ)) begin
        freq_r <= m_dat_i;
      end
      if (req && m_ack_i && (state == S_RD_DUR)) begin
        dur_r <= m_dat_i[DUR_W-1:0];
      end

      if ((state == S_IDLE) || (state == S_FIN)) begin
        abort_pend <= 1'b0;
      end else if (abort) begin
        abort_pend <= 1'b1;
      end

      if ((state == S_IDLE) && start) begin
        ptr       <= table_addr;
        remaining <= note_count;
`ifdef WB_MELODY_LOOP_EN
        first_addr  <= table_addr;
        first_count <= note_count;
`endif
      end

      if ((state == S_WR_STOP) && phase && !abort_eff) begin
`ifdef WB_MELODY_LOOP_EN
        if (remaining == 16'd1) begin
          ptr       <= first_addr;
          remaining <= first_count;
        end else begin
          ptr       <= ptr + 32'd8;
          remaining <= remaining - 16'd1;
        end
`else
        ptr       <= ptr + 32'd8;
        remaining <= remaining - 16'd1;
`endif
      end

      // Prescaler and tick count sit at zero outside WAIT, so every wait
      // starts from a fresh prescaler phase.
      if (state != S_WAIT) begin
        presc <= 32'd0;
        ticks <= '0;
      end else if (presc == PRESC_LAST) begin
        presc <= 32'd0;
        ticks <= ticks + DUR_ONE;
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_melody_player.sv
// tb_wb_melody_player
// Directed bench for wb_melody_player with TICK_DIV = 4 and the note
// peripheral at 0x8000_0000. A small memory model answers table reads,
// with programmable ack delay and an option to withhold write acks. A
// monitor logs each completed transfer with the idle cycles before it and
// the number of cycles its request was held.

module tb_wb_melody_player;

  localparam logic [31:0] NB     = 32'h8000_0000;
  localparam logic [31:0] STOP_A = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] table_addr;
  logic [15:0] note_count;
  logic        busy;
  logic        done;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_adr_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  always #5 clk = ~clk;

  wb_melody_player #(
    .NOTAS_BASE(NB),
    .TICK_DIV  (4),
    .DUR_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .table_addr(table_addr),
    .note_count(note_count),
    .busy      (busy),
    .done      (done),
    .m_cyc_o   (m_cyc_o),
    .m_stb_o   (m_stb_o),
    .m_we_o    (m_we_o),
    .m_adr_o   (m_adr_o),
    .m_sel_o   (m_sel_o),
    .m_dat_o   (m_dat_o),
    .m_dat_i   (m_dat_i),
    .m_ack_i   (m_ack_i)
  );

  // Memory model: 256 words covering byte addresses 0x000-0x3FF.
  logic [31:0] mem [0:255];
  int          ack_delay;
  logic        wr_ack_en;
  int          wait_cnt;

  assign m_dat_i = mem[m_adr_o[9:2]];
  assign m_ack_i = m_cyc_o && m_stb_o && (wait_cnt >= ack_delay) &&
                   (wr_ack_en || !m_we_o);

  always @(posedge clk) begin
    if (m_cyc_o && m_stb_o && !m_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Transfer monitor.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          gap;
    int          hold;
  } xfer_t;

  xfer_t       log_q[$];
  int          idle_cnt     = 0;
  int          hold_cnt     = 0;
  int          done_cnt     = 0;
  int          cyc_cycles   = 0;
  int          unstable_cnt = 0;
  logic        prev_req     = 1'b0;
  logic [64:0] prev_bus     = '0;

  always @(posedge clk) begin
    if (m_cyc_o) cyc_cycles <= cyc_cycles + 1;
    else idle_cnt <= idle_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (m_cyc_o && m_stb_o) begin
      if (prev_req && (prev_bus !== {m_we_o, m_adr_o, m_dat_o}))
        unstable_cnt <= unstable_cnt + 1;
      if (m_ack_i) begin
        log_q.push_back('{we: m_we_o, adr: m_adr_o,
                          dat: (m_we_o ? m_dat_o : 32'd0), sel: m_sel_o,
                          gap: idle_cnt, hold: hold_cnt + 1});
        idle_cnt <= 0;
        hold_cnt <= 0;
        prev_req <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1;
        prev_req <= 1'b1;
        prev_bus <= {m_we_o, m_adr_o, m_dat_o};
      end
    end else begin
      hold_cnt <= 0;
      prev_req <= 1'b0;
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int rd_idx = 0;

  task automatic check_bits(input string tag, input logic [71:0] obs,
                            input logic [71:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_xfer(input string tag, input logic we,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input int gap, input int hold);
    if (rd_idx >= log_q.size()) begin
      check_int({tag, "_present"}, log_q.size(), rd_idx + 1);
    end else begin
      check_bits({tag, "_bus"},
                 72'({log_q[rd_idx].we, log_q[rd_idx].adr, log_q[rd_idx].dat}),
                 72'({we, adr, dat}));
      check_bits({tag, "_sel"}, 72'(log_q[rd_idx].sel), 72'(4'hF));
      if (gap >= 0) check_int({tag, "_gap"}, log_q[rd_idx].gap, gap);
      check_int({tag, "_hold"}, log_q[rd_idx].hold, hold);
    end
    rd_idx++;
  endtask

  task automatic pulse_start(input logic [31:0] addr, input logic [15:0] cnt,
                             input logic with_abort);
    table_addr = addr;
    note_count = cnt;
    start      = 1'b1;
    abort      = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string tag);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_bits({tag, "_done_seen"}, 72'(done), 72'(1'b1));
    @(negedge clk);
    check_bits({tag, "_busy_after"}, 72'(busy), 72'(1'b0));
  endtask

  task automatic wait_log(input int target, input int max_cycles,
                          input string tag);
    int n = 0;
    while (log_q.size() < target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_int({tag, "_reached"}, (log_q.size() >= target) ? 1 : 0, 1);
  endtask

  // Three-entry song at 0x100: {440,3}, {0,2} (rest), {880,1}.
  task automatic run_song(input string p, input int hold);
    int base;
    int d0;
    base   = log_q.size();
    rd_idx = base;
    d0     = done_cnt;
    pulse_start(32'h100, 16'd3, 1'b0);
    wait_done(1000, p);
    expect_xfer({p, "_rd_f0"},  1'b0, 32'h100, 32'd0,   -1, hold);
    expect_xfer({p, "_rd_d0"},  1'b0, 32'h104, 32'd0,    1, hold);
    expect_xfer({p, "_wr_f0"},  1'b1, NB,      32'd440,  1, hold);
    expect_xfer({p, "_wr_go0"}, 1'b1, STOP_A,  32'd0,    1, hold);
    expect_xfer({p, "_wr_st0"}, 1'b1, STOP_A,  32'd1,   13, hold);
    expect_xfer({p, "_rd_f1"},  1'b0, 32'h108, 32'd0,    1, hold);
    expect_xfer({p, "_rd_d1"},  1'b0, 32'h10C, 32'd0,    1, hold);
    expect_xfer({p, "_wr_st1"}, 1'b1, STOP_A,  32'd1,    9, hold);
    expect_xfer({p, "_rd_f2"},  1'b0, 32'h110, 32'd0,    1, hold);
    expect_xfer({p, "_rd_d2"},  1'b0, 32'h114, 32'd0,    1, hold);
    expect_xfer({p, "_wr_f2"},  1'b1, NB,      32'd880,  1, hold);
    expect_xfer({p, "_wr_go2"}, 1'b1, STOP_A,  32'd0,    1, hold);
    expect_xfer({p, "_wr_st2"}, 1'b1, STOP_A,  32'd1,    5, hold);
    check_int({p, "_xfer_count"}, log_q.size() - base, 13);
    check_int({p, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int base;
    int d0;
    int c0;
    int n;

    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    table_addr = 32'd0;
    note_count = 16'd0;
    ack_delay  = 0;
    wr_ack_en  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'd440; mem[8'h41] = 32'd3;
    mem[8'h42] = 32'd0;   mem[8'h43] = 32'd2;
    mem[8'h44] = 32'd880; mem[8'h45] = 32'd1;
    mem[8'h80] = 32'd440; mem[8'h81] = 32'd1000;
    mem[8'h82] = 32'd880; mem[8'h83] = 32'd1;
    mem[8'hC0] = 32'd440; mem[8'hC1] = 32'h0007_0001;
    mem[8'hC2] = 32'd880; mem[8'hC3] = 32'd2;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    check_bits("reset_bus", 72'({m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o}),
               72'(0));
    check_bits("reset_status", 72'({busy, done}), 72'(2'b00));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] note_count zero");
    c0 = cyc_cycles;
    d0 = done_cnt;
    pulse_start(32'h100, 16'd0, 1'b0);
    check_bits("zero_fin", 72'({busy, done}), 72'(2'b11));
    @(negedge clk);
    check_bits("zero_idle", 72'({busy, done}), 72'(2'b00));
    repeat (3) @(negedge clk);
    check_int("zero_no_cyc", cyc_cycles - c0, 0);
    check_int("zero_done_pulses", done_cnt - d0, 1);

`ifndef WB_MELODY_LOOP_EN
    $display("[TB] song with zero-wait ack");
    run_song("nom", 1);

    $display("[TB] song with ack delayed 5 cycles");
    ack_delay = 5;
    run_song("ack5", 6);
    check_int("ack5_stable", unstable_cnt, 0);
    ack_delay = 0;
`endif

    // Start and abort together from idle: start wins. A later abort in
    // the 1000-tick wait cuts straight to the stop write.
    $display("[TB] abort during wait");
    base   = log_q.size();
    rd_idx = base;
    d0     = done_cnt;
    pulse_start(32'h200, 16'd2, 1'b1);
    wait_log(base + 4, 200, "ab_go");
    repeat (10) @(negedge clk);
    check_bits("ab_still_busy", 72'(busy), 72'(1'b1));
    check_int("ab_no_done_yet", done_cnt - d0, 0);
    pulse_abort();
    wait_done(100, "ab");
    repeat (5) @(negedge clk);
    expect_xfer("ab_rd_f0",  1'b0, 32'h200, 32'd0,   -1, 1);
    expect_xfer("ab_rd_d0",  1'b0, 32'h204, 32'd0,    1, 1);
    expect_xfer("ab_wr_f0",  1'b1, NB,      32'd440,  1, 1);
    expect_xfer("ab_wr_go0", 1'b1, STOP_A,  32'd0,    1, 1);
    expect_xfer("ab_wr_st0", 1'b1, STOP_A,  32'd1,   -1, 1);
    check_int("ab_xfer_count", log_q.size() - base, 5);
    check_int("ab_done_pulses", done_cnt - d0, 1);

`ifndef WB_MELODY_LOOP_EN
    $display("[TB] reset during unacked write");
    wr_ack_en = 1'b0;
    pulse_start(32'h100, 16'd3, 1'b0);
    n = 0;
    while (!(m_cyc_o && m_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bits("rst_write_pending", 72'({m_cyc_o, m_we_o}), 72'(2'b11));
    #2 reset = 1'b1;
    #1;
    check_bits("rst_async_drop", 72'({m_cyc_o, m_stb_o, busy}), 72'(3'b000));
    @(negedge clk);
    reset     = 1'b0;
    wr_ack_en = 1'b1;
    @(negedge clk);
    run_song("rst", 1);
`else
    // Loop build: two entries replay from table_addr with no done pulse;
    // the upper duration bits of the first entry must be ignored.
    $display("[TB] loop playback");
    base   = log_q.size();
    rd_idx = base;
    d0     = done_cnt;
    pulse_start(32'h300, 16'd2, 1'b0);
    wait_log(base + 12, 400, "lp");
    check_int("lp_no_done", done_cnt - d0, 0);
    pulse_abort();
    wait_done(100, "lp");
    repeat (5) @(negedge clk);
    expect_xfer("lp_rd_f0",  1'b0, 32'h300, 32'd0,   -1, 1);
    expect_xfer("lp_rd_d0",  1'b0, 32'h304, 32'd0,    1, 1);
    expect_xfer("lp_wr_f0",  1'b1, NB,      32'd440,  1, 1);
    expect_xfer("lp_wr_go0", 1'b1, STOP_A,  32'd0,    1, 1);
    expect_xfer("lp_wr_st0", 1'b1, STOP_A,  32'd1,    5, 1);
    expect_xfer("lp_rd_f1",  1'b0, 32'h308, 32'd0,    1, 1);
    expect_xfer("lp_rd_d1",  1'b0, 32'h30C, 32'd0,    1, 1);
    expect_xfer("lp_wr_f1",  1'b1, NB,      32'd880,  1, 1);
    expect_xfer("lp_wr_go1", 1'b1, STOP_A,  32'd0,    1, 1);
    expect_xfer("lp_wr_st1", 1'b1, STOP_A,  32'd1,    9, 1);
    expect_xfer("lp_rd_f2",  1'b0, 32'h300, 32'd0,    1, 1);
    expect_xfer("lp_rd_d2",  1'b0, 32'h304, 32'd0,    1, 1);
    expect_xfer("lp_wr_st2", 1'b1, STOP_A,  32'd1,    1, 1);
    check_int("lp_xfer_count", log_q.size() - base, 13);
    check_int("lp_done_pulses", done_cnt - d0, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
